mux_scan_ctrl: RTL and testbench

Upstream sequencer for the team's 8:1 single-bit mux. It drives the mux's 3-bit select, waits a settle window on each enabled channel, and samples the mux output back into an 8-bit parallel word. A start/busy/done handshake lets a controller trigger one scan of up to 8 channels and collect the result.

---
 rtl/mux_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 single-bit mux: steps sel across enabled channels, dwells, samples.
// Optional continuous re-scan mode is compiled in with `define MUX_SCAN_CONT_EN.
`timescale 1ns/1ps

module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef MUX_SCAN_CONT_EN
    input  logic       cont,
`endif
    input  logic [7:0] mask,
    input  logic       mux_in,
    output logic [2:0] sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] data
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [3:0] DwellLoad = 4'(DWELL - 1);

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] data_q, data_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] remaining;
    logic       launch;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

`ifdef MUX_SCAN_CONT_EN
    logic cont_q, cont_d;

    // cont is captured on the edge entering DONE; it re-launches from the DONE cycle.
    assign launch = start | (cont_q & (state_q == StDone));
`else
    assign launch = start;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        mask_d    = mask_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        remaining = mask_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                sel_d   = 3'd0;
                if (launch) begin
                    data_d = 8'h00;
                    if (mask != 8'h00) begin
                        state_d = StScan;
                        mask_d  = mask;
                        sel_d   = lowest_set(mask);
                        cnt_d   = DwellLoad;
                    end else begin
                        state_d = StDone;
                        mask_d  = 8'h00;
                    end
                end
            end
            StScan: begin
                if (cnt_q == 4'd0) begin
                    data_d[sel_q] = mux_in;
                    remaining     = mask_q & ~(8'd1 << sel_q);
                    mask_d        = remaining;
                    // Lower bits are already cleared, so the lowest remaining bit is the next one up.
                    if (remaining != 8'h00) begin
                        sel_d = lowest_set(remaining);
                        cnt_d = DwellLoad;
                    end else begin
                        state_d = StDone;
                        sel_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef MUX_SCAN_CONT_EN
    always_comb begin
        cont_d = 1'b0;
        if (state_d == StDone) cont_d = cont;
    end

    always_ff @(posedge clk) begin
        if (rst) cont_q <= 1'b0;
        else     cont_q <= cont_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 3'd0;
            mask_q  <= 8'h00;
            data_q  <= 8'h00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel  = sel_q;
    assign busy = (state_q == StScan);
    assign done = (state_q == StDone);
    assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: a cycle-stamped model predicts the sel trace and each result.
// Exercises continuous mode too when built with MUX_SCAN_CONT_EN.
`timescale 1ns/1ps

module tb_mux_scan_ctrl;

    localparam int unsigned DWELL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] mask = 8'h00;
    logic       mux_in;
    logic [2:0] sel;
    logic       busy;
    logic       done;
    logic [7:0] data;

    logic [7:0] pattern = 8'h00;
    logic [7:0] new_pat = 8'h00;

    // Behavioural mux: channel n returns pattern bit n.
    assign mux_in = pattern[sel];

    mux_scan_ctrl #(.DWELL(DWELL)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
`ifdef MUX_SCAN_CONT_EN
        .cont   (cont),
`endif
        .mask   (mask),
        .mux_in (mux_in),
        .sel    (sel),
        .busy   (busy),
        .done   (done),
        .data   (data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {logic [2:0] s; int at;} sel_t;
    typedef struct {logic [7:0] d; int at;} res_t;

    sel_t       sel_q[$];
    res_t       res_q[$];
    sel_t       ms;
    res_t       mr;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [7:0] hold_data = 8'h00;
    int         busy_end = 0;
    int         cont_edge = -1;
    bit         pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model of one clock edge: a request at edge e is taken only once the previous scan's
    // final sampling edge (busy_end) has passed. Scan of k channels ends at e + k*DWELL.
    task automatic step();
        int e;
        int k;
        int idx;
        bit go;
        e  = cyc + 1;
        go = start || (pending && e == busy_end + 1);
        if (e == cont_edge) pending = cont;
        if (!rst && go && e > busy_end) begin
            k       = $countones(mask);
            pattern = new_pat;
            idx     = 0;
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) begin
                    for (int j = 0; j < int'(DWELL); j++) begin
                        sel_q.push_back('{s: 3'(i), at: e + idx});
                        idx++;
                    end
                end
            end
            busy_end = e + k * int'(DWELL);
            res_q.push_back('{d: new_pat & mask, at: busy_end});
            if (k == 0) begin
                pending   = cont;
                cont_edge = -1;
            end else begin
                cont_edge = busy_end;
            end
        end
    endtask

    task automatic tick();
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (cyc <= busy_end + 1 && g < 500) begin
            tick();
            g++;
        end
    endtask

    task automatic apply_reset_and_check(input string tag);
        rst    = 1'b1;
        mon_en = 1'b0;
        tick();
        @(negedge clk);
        chk({tag, "_sel"},  sel,  0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_data"}, data, 0);
        rst = 1'b0;
        sel_q.delete();
        res_q.delete();
        busy_end  = cyc;
        pending   = 1'b0;
        cont_edge = -1;
        hold_data = 8'h00;
        tick();
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) begin
                if (sel_q.size() == 0) begin
                    chk("busy_unexpected", busy, 0);
                end else begin
                    ms = sel_q.pop_front();
                    chk("sel", sel, ms.s);
                    chk("sel_cycle", cyc, ms.at);
                end
            end else if (sel_q.size() != 0 && sel_q[0].at <= cyc) begin
                void'(sel_q.pop_front());
                chk("busy", busy, 1);
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    chk("done_unexpected", done, 0);
                end else begin
                    mr = res_q.pop_front();
                    chk("data", data, mr.d);
                    chk("done_cycle", cyc, mr.at);
                    hold_data = mr.d;
                end
            end else if (res_q.size() != 0 && res_q[0].at <= cyc) begin
                void'(res_q.pop_front());
                chk("done", done, 1);
            end
            if (busy && done) chk("busy_and_done", done, 0);
            if (!busy && !done) chk("data_hold", data, hold_data);
        end
    end

    initial begin
        int g;
        apply_reset_and_check("reset");

        // Full scan, pattern A5.
        new_pat = 8'hA5; mask = 8'hFF; start = 1'b1; tick(); start = 1'b0;
        wait_idle();

        // Sparse mask: only channels 0 and 7.
        new_pat = 8'hFF; mask = 8'h81; start = 1'b1; tick(); start = 1'b0;
        wait_idle();

        // Empty mask goes straight to DONE with data 0.
        new_pat = 8'hFF; mask = 8'h00; start = 1'b1; tick(); start = 1'b0;
        wait_idle();

        // Second start during a scan must be ignored.
        new_pat = 8'($urandom); mask = 8'h0F; start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        new_pat = 8'($urandom); mask = 8'hF0; start = 1'b1; tick(); start = 1'b0;
        wait_idle();

        // Reset in the middle of a scan, then a clean full scan.
        new_pat = 8'($urandom); mask = 8'hFF; start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        apply_reset_and_check("midscan_rst");
        new_pat = 8'($urandom); mask = 8'hFF; start = 1'b1; tick(); start = 1'b0;
        wait_idle();

        // Start held high: back-to-back scans, fresh data each time.
        mask = 8'h03; start = 1'b1;
        repeat (16) begin
            new_pat = 8'($urandom);
            tick();
        end
        start = 1'b0;
        wait_idle();

`ifdef MUX_SCAN_CONT_EN
        // Continuous mode keeps re-launching with start low.
        cont = 1'b1; mask = 8'h03; new_pat = 8'($urandom); start = 1'b1; tick(); start = 1'b0;
        repeat (16) begin
            new_pat = 8'($urandom);
            tick();
        end
        cont = 1'b0;
        wait_idle();
`endif

        // Random scans; mask is scrambled while busy and some starts land mid-scan.
        repeat (40) begin
            new_pat = 8'($urandom);
            mask    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            start   = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            start = 1'b0;
            mask  = 8'($urandom);
            repeat ($urandom_range(0, 18)) tick();
        end

        g = 0;
        while ((sel_q.size() != 0 || res_q.size() != 0) && g < 200) begin
            tick();
            g++;
        end
        tick(); tick();
        chk("drain", sel_q.size() + res_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
